// File: rtl/mmio_rd_pkg.sv
// ---------------------------------------------------------------------------
// mmio_rd_pkg
// Shared definitions for the MMIO read responder slice:
//   - completion status codes written to cc_status
//   - largest completion payload in DWords
//   - FSM state encoding used by mmio_read_responder
//   - request word width helper used to size the request FIFO
// ---------------------------------------------------------------------------
package mmio_rd_pkg;

   // Completion status codes
   localparam logic [2:0] CPL_SC = 3'b000;
   localparam logic [2:0] CPL_UR = 3'b001;
   localparam logic [2:0] CPL_CA = 3'b100;

   // Largest payload one completion can carry
   localparam int MAX_CPL_DW = 4;

   // Request word without the address: id(16) + tag(8) + tc(3) + dword_count(11)
   localparam int REQ_META_W = 16 + 8 + 3 + 11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_SEND
   } rd_state_e;

   // Address bits [1:0] are ignored, so only the DWord part is queued
   function automatic int reqWidth(input int addrW);
      return REQ_META_W + addrW - 2;
   endfunction

endpackage

// File: rtl/mmio_req_fifo.sv
// ---------------------------------------------------------------------------
// mmio_req_fifo
// Synchronous request FIFO holding parsed MMIO read requests.
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset, empties the FIFO
//   push_i       write pushData_i (ignored when full)
//   pushData_i   request word
//   pop_i        advance read pointer (ignored when empty)
//   popData_o    head entry, valid while !empty_o
//   full_o       FIFO holds DEPTH entries
//   empty_o      FIFO holds no entries
//   fullNext_o   FIFO will be full after this cycle's push/pop
// ---------------------------------------------------------------------------
module mmio_req_fifo #(
   parameter int WIDTH = 56,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] popData_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             fullNext_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W:0]   count_q;
   logic [PTR_W:0]   count_d;
   logic             doPush;
   logic             doPop;

   assign full_o    = (count_q == FULL_CNT);
   assign empty_o   = (count_q == '0);
   assign doPush    = push_i & ~full_o;
   assign doPop     = pop_i & ~empty_o;
   assign popData_o = mem_q[rdPtr_q];
   assign fullNext_o = (count_d == FULL_CNT);

   // Occupancy after this cycle; also feeds the registered ready upstream
   always_comb begin
      count_d = count_q;
      if (doPush && !doPop) begin
         count_d = count_q + 1'b1;
      end else if (doPop && !doPush) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointers and occupancy; reset discards everything queued
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   // Storage array carries no reset; entries are only read while counted
   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

endmodule

// File: rtl/mmio_read_responder.sv
// ---------------------------------------------------------------------------
// mmio_read_responder
// Queues parsed MMIO read requests, fetches up to 4 DWords per request from
// the user register file and returns one single-beat completion per request.
// Optional feature: define MMIO_RD_TIMEOUT_EN to add a per-DWord read timeout
// that completes the request with Completer Abort.
// Ports:
//   user_clk / user_reset        clock, synchronous active-high reset
//   req_*                        parsed read request (valid/ready handshake)
//   rd_en / rd_addr              one-cycle register read strobe and address
//   rd_valid / rd_data           read return, any latency >= 1 cycle
//   cc_*                         completion (valid/ready handshake, single beat)
// ---------------------------------------------------------------------------
module mmio_read_responder
   import mmio_rd_pkg::*;
#(
   parameter int ADDR_W     = 20,
   parameter int REG_BYTES  = 4096,
   parameter int REQ_DEPTH  = 4,
   parameter int RD_TIMEOUT = 64
) (
   input  logic              user_clk,
   input  logic              user_reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [15:0]       req_requester_id,
   input  logic [7:0]        req_tag,
   input  logic [2:0]        req_tc,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [10:0]       req_dword_count,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_valid,
   input  logic [31:0]       rd_data,
   output logic              cc_valid,
   input  logic              cc_ready,
   output logic [15:0]       cc_requester_id,
   output logic [7:0]        cc_tag,
   output logic [2:0]        cc_tc,
   output logic [6:0]        cc_lower_addr,
   output logic [10:0]       cc_dword_count,
   output logic [2:0]        cc_status,
   output logic [127:0]      cc_data,
   output logic              cc_last
);

   localparam int REQ_W = reqWidth(ADDR_W);
   localparam int AW3   = ADDR_W + 3;
   localparam logic [AW3-1:0] REG_LIMIT = AW3'(REG_BYTES);

   // Low address bits carry no meaning for DWord reads
   logic unusedAddrBits;
   assign unusedAddrBits = ^req_addr[1:0];

   logic             reqReady_q;
   logic             fifoPush;
   logic             fifoPop;
   logic [REQ_W-1:0] pushData;
   logic [REQ_W-1:0] popData;
   logic             fifoFull;
   logic             fifoEmpty;
   logic             fifoFullNext;

   logic [15:0]       popId;
   logic [7:0]        popTag;
   logic [2:0]        popTc;
   logic [ADDR_W-3:0] popAddrHi;
   logic [10:0]       popCount;
   logic [AW3-1:0]    popBase;
   logic [AW3-1:0]    popEnd;
   logic              popLegal;

   rd_state_e         state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        count_q;
   logic [2:0]        idx_q;
   logic [2:0]        idxInc;
   logic              freshRead;

   logic              rdEn_q;
   logic [ADDR_W-1:0] rdAddr_q;
   logic              ccValid_q;
   logic [15:0]       ccId_q;
   logic [7:0]        ccTag_q;
   logic [2:0]        ccTc_q;
   logic [6:0]        ccLower_q;
   logic [10:0]       ccCount_q;
   logic [2:0]        ccStatus_q;
   logic [127:0]      data_q;

   assign pushData = {req_requester_id, req_tag, req_tc, req_addr[ADDR_W-1:2], req_dword_count};
   assign fifoPush = req_valid & reqReady_q;
   assign fifoPop  = (state_q == ST_IDLE) & ~fifoEmpty;

   mmio_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (REQ_DEPTH)
   ) uReqFifo (
      .clk_i      (user_clk),
      .reset_i    (user_reset),
      .push_i     (fifoPush),
      .pushData_i (pushData),
      .pop_i      (fifoPop),
      .popData_o  (popData),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty),
      .fullNext_o (fifoFullNext)
   );

   assign {popId, popTag, popTc, popAddrHi, popCount} = popData;

   // Range check is done three bits wider than the address so a huge
   // dword_count or an address near the top can never wrap into range
   assign popBase  = {3'b000, popAddrHi, 2'b00};
   assign popEnd   = popBase + AW3'({popCount, 2'b00});
   assign popLegal = (popCount != 11'd0) && (popCount <= 11'(MAX_CPL_DW)) && (popEnd <= REG_LIMIT);

   assign idxInc = idx_q + 3'd1;

   // Ready is the registered inverse of the FIFO's next-cycle full flag,
   // so a push accepted this cycle can never overflow
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         reqReady_q <= 1'b0;
      end else begin
         reqReady_q <= ~fifoFullNext;
      end
   end

`ifdef MMIO_RD_TIMEOUT_EN
   localparam int TMR_W = $clog2(RD_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RD_TIMEOUT - 1);

   logic [TMR_W-1:0] timer_q;
   logic [2:0]       stale_q;
   logic             timeoutFire;

   // A read that timed out may still return later; stale_q counts those
   // owed returns so they are swallowed instead of landing in a later request
   assign freshRead   = (stale_q == 3'd0);
   assign timeoutFire = (state_q == ST_WAIT) && !(rd_valid && freshRead) && (timer_q == TMR_LAST);

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         stale_q <= 3'd0;
      end else begin
         case ({timeoutFire, rd_valid && !freshRead})
            2'b10:   stale_q <= (stale_q == 3'd7) ? stale_q : stale_q + 3'd1;
            2'b01:   stale_q <= stale_q - 3'd1;
            default: stale_q <= stale_q;
         endcase
      end
   end
`else
   assign freshRead = 1'b1;
`endif

   // Main control: pop one request, fetch its DWords one at a time, then
   // hold the completion until the formatter takes it
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         count_q    <= 3'd0;
         idx_q      <= 3'd0;
         rdEn_q     <= 1'b0;
         rdAddr_q   <= '0;
         ccValid_q  <= 1'b0;
         ccId_q     <= 16'd0;
         ccTag_q    <= 8'd0;
         ccTc_q     <= 3'd0;
         ccLower_q  <= 7'd0;
         ccCount_q  <= 11'd0;
         ccStatus_q <= CPL_SC;
         data_q     <= '0;
`ifdef MMIO_RD_TIMEOUT_EN
         timer_q    <= '0;
`endif
      end else begin
         rdEn_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (!fifoEmpty) begin
                  ccId_q    <= popId;
                  ccTag_q   <= popTag;
                  ccTc_q    <= popTc;
                  ccLower_q <= {popAddrHi[4:0], 2'b00};
                  addr_q    <= {popAddrHi, 2'b00};
                  idx_q     <= 3'd0;
                  data_q    <= '0;
                  if (popLegal) begin
                     count_q    <= popCount[2:0];
                     ccCount_q  <= popCount;
                     ccStatus_q <= CPL_SC;
                     rdEn_q     <= 1'b1;
                     rdAddr_q   <= {popAddrHi, 2'b00};
                     state_q    <= ST_FETCH;
                  end else begin
                     count_q    <= 3'd0;
                     ccCount_q  <= 11'd0;
                     ccStatus_q <= CPL_UR;
                     ccValid_q  <= 1'b1;
                     state_q    <= ST_SEND;
                  end
               end
            end
            ST_FETCH: begin
`ifdef MMIO_RD_TIMEOUT_EN
               timer_q <= '0;
`endif
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (rd_valid && freshRead) begin
                  data_q[{idx_q[1:0], 5'b00000} +: 32] <= rd_data;
                  idx_q <= idxInc;
                  if (idxInc == count_q) begin
                     ccValid_q <= 1'b1;
                     state_q   <= ST_SEND;
                  end else begin
                     rdEn_q   <= 1'b1;
                     rdAddr_q <= addr_q + ADDR_W'({idxInc, 2'b00});
                     state_q  <= ST_FETCH;
                  end
`ifdef MMIO_RD_TIMEOUT_EN
               end else if (timeoutFire) begin
                  ccStatus_q <= CPL_CA;
                  ccCount_q  <= 11'd0;
                  data_q     <= '0;
                  ccValid_q  <= 1'b1;
                  state_q    <= ST_SEND;
               end else begin
                  timer_q <= timer_q + 1'b1;
`endif
               end
            end
            ST_SEND: begin
               if (cc_ready) begin
                  ccValid_q <= 1'b0;
                  data_q    <= '0;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready       = reqReady_q;
   assign rd_en           = rdEn_q;
   assign rd_addr         = rdAddr_q;
   assign cc_valid        = ccValid_q;
   assign cc_requester_id = ccId_q;
   assign cc_tag          = ccTag_q;
   assign cc_tc           = ccTc_q;
   assign cc_lower_addr   = ccLower_q;
   assign cc_dword_count  = ccCount_q;
   assign cc_status       = ccStatus_q;
   assign cc_data         = data_q;
   assign cc_last         = ccValid_q;

endmodule
